// File: rtl/ct_ebiu_ncwt_pkg.sv
// Shared types and constants for the EBIU NC write-table response path.
package ct_ebiu_ncwt_pkg;

  localparam int unsigned NCWT_NUM_DEF = 8;
  localparam int unsigned PIU_NUM_DEF  = 4;

  localparam int unsigned ID_W       = 8;
  localparam int unsigned BRESP_W    = 2;
  localparam int unsigned NCWT_BUS_W = 10;
  localparam int unsigned ID_LSB     = 2;
  localparam int unsigned BRESP_LSB  = 0;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [BRESP_W-1:0] bresp;
  } ncwt_bus_t;

  // SLVERR and DECERR both carry bit 1.
  function automatic logic bresp_is_err(input logic [BRESP_W-1:0] bresp);
    return bresp[1];
  endfunction

endpackage

// File: rtl/ct_ebiu_rr_arb_nc.sv
// Round-robin picker: first requester at or after ptr, wrapping; N must be a power of 2.
module ct_ebiu_rr_arb_nc #(
  parameter int unsigned N = 8,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + IDX_W'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt[gnt_idx] = gnt_vld;
  end

endmodule

// File: rtl/ct_ebiu_ncwt_bresp_arb.sv
// Arbitrates ncwt entry write responses onto the per-PIU B channels through a single slot.
// Optional: define EBIU_NCWT_BRESP_ERR_CNT_EN to add the saturating error-response counter.
module ct_ebiu_ncwt_bresp_arb
  import ct_ebiu_ncwt_pkg::*;
#(
  parameter int unsigned NCWT_NUM = NCWT_NUM_DEF,
  parameter int unsigned PIU_NUM  = PIU_NUM_DEF
) (
  input  logic                           ncwt_ctrl_clk,
  input  logic                           cpurst_b,
  input  logic [NCWT_NUM-1:0]            ncwt_bvalid_vec,
  input  logic [NCWT_NUM*NCWT_BUS_W-1:0] ncwt_bus_flat,
  input  logic [NCWT_NUM*PIU_NUM-1:0]    ncwt_piu_sel_flat,
  input  logic [PIU_NUM-1:0]             piu_ebiu_bready,
  output logic [NCWT_NUM-1:0]            ncwt_bresp_accept_en,
  output logic [PIU_NUM-1:0]             ebiu_piu_bvalid,
  output logic [ID_W-1:0]                ebiu_piu_bid,
  output logic [BRESP_W-1:0]             ebiu_piu_bresp,
  output logic                           ncwt_bresp_busy
`ifdef EBIU_NCWT_BRESP_ERR_CNT_EN
  ,
  output logic [7:0]                     ncwt_bresp_err_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NCWT_NUM);

  ncwt_bus_t          bus_arr [NCWT_NUM];
  logic [PIU_NUM-1:0] sel_arr [NCWT_NUM];

  for (genvar i = 0; i < NCWT_NUM; i++) begin : g_unpack
    assign bus_arr[i].id    = ncwt_bus_flat[i*NCWT_BUS_W+ID_LSB +: ID_W];
    assign bus_arr[i].bresp = ncwt_bus_flat[i*NCWT_BUS_W+BRESP_LSB +: BRESP_W];
    assign sel_arr[i]       = ncwt_piu_sel_flat[i*PIU_NUM +: PIU_NUM];
  end

  logic [PIU_NUM-1:0]  pend_q;
  logic [PIU_NUM-1:0]  pend_left;
  ncwt_bus_t           slot_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [NCWT_NUM-1:0] gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic                slot_free;
  logic                load;

  ct_ebiu_rr_arb_nc #(
    .N (NCWT_NUM)
  ) u_rr_arb (
    .req     (ncwt_bvalid_vec),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Slot is reusable this cycle if every still-pending PIU is handshaking now.
  assign pend_left = pend_q & ~piu_ebiu_bready;
  assign slot_free = ~|pend_left;
  // Reset gating keeps the accept pulse quiet while the entries are being reset.
  assign load      = slot_free & gnt_vld & cpurst_b;

  assign ncwt_bresp_accept_en = load ? gnt : '0;
  assign ebiu_piu_bvalid      = pend_q;
  assign ebiu_piu_bid         = slot_q.id;
  assign ebiu_piu_bresp       = slot_q.bresp;
  assign ncwt_bresp_busy      = |pend_q;

  always_ff @(posedge ncwt_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pend_q   <= '0;
      slot_q   <= '0;
      rr_ptr_q <= '0;
    end else if (load) begin
      pend_q   <= sel_arr[gnt_idx];
      slot_q   <= bus_arr[gnt_idx];
      rr_ptr_q <= gnt_idx + IDX_W'(1);
    end else begin
      pend_q   <= pend_left;
    end
  end

`ifdef EBIU_NCWT_BRESP_ERR_CNT_EN
  always_ff @(posedge ncwt_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ncwt_bresp_err_cnt <= '0;
    end else if (load && bresp_is_err(bus_arr[gnt_idx].bresp)
                 && (ncwt_bresp_err_cnt != 8'hFF)) begin
      ncwt_bresp_err_cnt <= ncwt_bresp_err_cnt + 8'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // resp_done is registered in the entry, so bvalid must fall the cycle after accept.
  for (genvar i = 0; i < NCWT_NUM; i++) begin : g_sva
    a_no_rebvalid: assert property (@(posedge ncwt_ctrl_clk) disable iff (!cpurst_b)
      ncwt_bresp_accept_en[i] |=> !ncwt_bvalid_vec[i]);
  end

  a_sel_nonzero: assert property (@(posedge ncwt_ctrl_clk) disable iff (!cpurst_b)
    load |-> |sel_arr[gnt_idx]);
`endif

endmodule

// File: tb/tb_ct_ebiu_ncwt_bresp_arb.sv
// Directed self-checking bench for ct_ebiu_ncwt_bresp_arb (8 entries, 4 PIUs).
module tb_ct_ebiu_ncwt_bresp_arb;

  logic        ncwt_ctrl_clk;
  logic        cpurst_b;
  logic [7:0]  bvalid_vec;
  logic [79:0] bus_flat;
  logic [31:0] sel_flat;
  logic [3:0]  bready;
  logic [7:0]  accept_en;
  logic [3:0]  piu_bvalid;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        busy;
`ifdef EBIU_NCWT_BRESP_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  ct_ebiu_ncwt_bresp_arb #(
    .NCWT_NUM (8),
    .PIU_NUM  (4)
  ) dut (
    .ncwt_ctrl_clk        (ncwt_ctrl_clk),
    .cpurst_b             (cpurst_b),
    .ncwt_bvalid_vec      (bvalid_vec),
    .ncwt_bus_flat        (bus_flat),
    .ncwt_piu_sel_flat    (sel_flat),
    .piu_ebiu_bready      (bready),
    .ncwt_bresp_accept_en (accept_en),
    .ebiu_piu_bvalid      (piu_bvalid),
    .ebiu_piu_bid         (bid),
    .ebiu_piu_bresp       (bresp),
    .ncwt_bresp_busy      (busy)
`ifdef EBIU_NCWT_BRESP_ERR_CNT_EN
    ,
    .ncwt_bresp_err_cnt   (err_cnt)
`endif
  );

  initial ncwt_ctrl_clk = 1'b0;
  always #5 ncwt_ctrl_clk = ~ncwt_ctrl_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ncwt_ctrl_clk);
    #1;
  endtask

  task automatic set_entry(input int e, input logic [7:0] id, input logic [1:0] br,
                           input logic [3:0] sel);
    bus_flat[e*10 +: 10] = {id, br};
    sel_flat[e*4 +: 4]   = sel;
  endtask

  task automatic do_reset();
    cpurst_b   = 1'b0;
    bvalid_vec = '0;
    bus_flat   = '0;
    sel_flat   = '0;
    bready     = '0;
    repeat (2) tick();
    cpurst_b = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    cpurst_b   = 1'b0;
    bvalid_vec = 8'hFF;
    sel_flat   = '1;
    bready     = '1;
    #1;
    n_vec++; if (piu_bvalid !== 4'b0000) begin n_err++;
      $display("FAIL reset_bvalid: got %b want 0000", piu_bvalid); end
    n_vec++; if (bid !== 8'h00) begin n_err++;
      $display("FAIL reset_bid: got %h want 00", bid); end
    n_vec++; if (bresp !== 2'b00) begin n_err++;
      $display("FAIL reset_bresp: got %b want 00", bresp); end
    n_vec++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (accept_en !== 8'h00) begin n_err++;
      $display("FAIL reset_accept: got %h want 00", accept_en); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_entry(3, 8'h23, 2'b00, 4'b0010);
    bvalid_vec = 8'h08;
    bready     = 4'b0010;
    #1;
    n_vec++; if (accept_en !== 8'h08) begin n_err++;
      $display("FAIL single_accept: got %h want 08", accept_en); end
    n_vec++; if (piu_bvalid !== 4'b0000) begin n_err++;
      $display("FAIL single_bvalid_c0: got %b want 0000", piu_bvalid); end
    tick();
    bvalid_vec = '0;
    #1;
    n_vec++; if (piu_bvalid !== 4'b0010) begin n_err++;
      $display("FAIL single_bvalid_c1: got %b want 0010", piu_bvalid); end
    n_vec++; if (bid !== 8'h23) begin n_err++;
      $display("FAIL single_bid: got %h want 23", bid); end
    n_vec++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL single_busy_c1: got %b want 1", busy); end
    n_vec++; if (accept_en !== 8'h00) begin n_err++;
      $display("FAIL single_accept_c1: got %h want 00", accept_en); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL single_busy_c2: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int         off [8];
    int         exp_idx [6] = '{0, 2, 5, 0, 2, 5};
    logic [7:0] mask;
    logic [7:0] exp_acc;
    do_reset();
    mask = 8'h25;
    for (int e = 0; e < 8; e++) off[e] = 0;
    set_entry(0, 8'h10, 2'b01, 4'b0001);
    set_entry(2, 8'h12, 2'b01, 4'b0001);
    set_entry(5, 8'h15, 2'b01, 4'b0001);
    bready = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      for (int e = 0; e < 8; e++) bvalid_vec[e] = mask[e] && (off[e] == 0);
      #1;
      exp_acc = 8'h01 << exp_idx[c];
      n_vec++; if (accept_en !== exp_acc) begin n_err++;
        $display("FAIL rr_grant c%0d: got %h want %h", c, accept_en, exp_acc); end
      if (c > 0) begin
        n_vec++; if (bid !== 8'(8'h10 + exp_idx[c-1])) begin n_err++;
          $display("FAIL rr_bid c%0d: got %h want %h", c, bid, 8'(8'h10 + exp_idx[c-1])); end
        n_vec++; if (piu_bvalid !== 4'b0001) begin n_err++;
          $display("FAIL rr_bvalid c%0d: got %b want 0001", c, piu_bvalid); end
      end
      for (int e = 0; e < 8; e++) if (off[e] > 0) off[e]--;
      off[exp_idx[c]] = 2;
      tick();
    end
    bvalid_vec = '0;
  endtask

  task automatic test_broadcast();
    logic [7:0] vld [8] = '{8'h10, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};
    logic [3:0] rdy [8] = '{4'b0000, 4'b0101, 4'b0101, 4'b0111,
                            4'b0111, 4'b1111, 4'b0000, 4'b0001};
    logic [7:0] acc [8] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
    logic [3:0] bv  [8] = '{4'b0000, 4'b1111, 4'b1010, 4'b1010,
                            4'b1000, 4'b1000, 4'b0001, 4'b0001};
    logic [7:0] ebid [8] = '{8'h00, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h77, 8'h77};
    do_reset();
    set_entry(4, 8'h44, 2'b01, 4'b1111);
    set_entry(7, 8'h77, 2'b00, 4'b0001);
    for (int c = 0; c < 8; c++) begin
      bvalid_vec = vld[c];
      bready     = rdy[c];
      #1;
      n_vec++; if (accept_en !== acc[c]) begin n_err++;
        $display("FAIL bcast_accept c%0d: got %h want %h", c, accept_en, acc[c]); end
      n_vec++; if (piu_bvalid !== bv[c]) begin n_err++;
        $display("FAIL bcast_bvalid c%0d: got %b want %b", c, piu_bvalid, bv[c]); end
      n_vec++; if (bid !== ebid[c]) begin n_err++;
        $display("FAIL bcast_bid c%0d: got %h want %h", c, bid, ebid[c]); end
      tick();
    end
    n_vec++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL bcast_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_entry(1, 8'h11, 2'b00, 4'b0100);
    set_entry(6, 8'h66, 2'b10, 4'b0010);
    bready     = 4'b1011;
    bvalid_vec = 8'h42;
    #1;
    n_vec++; if (accept_en !== 8'h02) begin n_err++;
      $display("FAIL bp_first: got %h want 02", accept_en); end
    tick();
    for (int c = 1; c <= 10; c++) begin
      bvalid_vec = 8'h40;
      #1;
      n_vec++; if (accept_en !== 8'h00) begin n_err++;
        $display("FAIL bp_hold c%0d: got %h want 00", c, accept_en); end
      n_vec++; if (piu_bvalid !== 4'b0100) begin n_err++;
        $display("FAIL bp_bvalid c%0d: got %b want 0100", c, piu_bvalid); end
      tick();
    end
    bready = 4'b1111;
    #1;
    n_vec++; if (accept_en !== 8'h40) begin n_err++;
      $display("FAIL bp_release: got %h want 40", accept_en); end
    tick();
    bvalid_vec = '0;
    #1;
    n_vec++; if (piu_bvalid !== 4'b0010) begin n_err++;
      $display("FAIL bp_next_bvalid: got %b want 0010", piu_bvalid); end
    n_vec++; if (bid !== 8'h66 || bresp !== 2'b10) begin n_err++;
      $display("FAIL bp_next_data: got %h/%b want 66/10", bid, bresp); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] exp_acc;
    do_reset();
    for (int e = 0; e < 4; e++) set_entry(e, 8'(8'hB0 + e), 2'(e), 4'b0001);
    bready = 4'b0001;
    for (int c = 0; c <= 4; c++) begin
      v = 8'h0F;
      bvalid_vec = (c < 4) ? ((v << c) & v) : 8'h00;
      #1;
      if (c < 4) begin
        exp_acc = 8'h01 << c;
        n_vec++; if (accept_en !== exp_acc) begin n_err++;
          $display("FAIL b2b_accept c%0d: got %h want %h", c, accept_en, exp_acc); end
      end
      if (c > 0) begin
        n_vec++; if (piu_bvalid !== 4'b0001 || bid !== 8'(8'hB0 + c - 1)
                     || bresp !== 2'(c - 1)) begin n_err++;
          $display("FAIL b2b_slot c%0d: got %b/%h/%b want 0001/%h/%b", c, piu_bvalid, bid,
                   bresp, 8'(8'hB0 + c - 1), 2'(c - 1)); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_entry(0, 8'h5A, 2'b00, 4'b0001);
    set_entry(2, 8'h5C, 2'b00, 4'b0010);
    bvalid_vec = 8'h04;
    #1;
    n_vec++; if (accept_en !== 8'h04) begin n_err++;
      $display("FAIL rmid_first: got %h want 04", accept_en); end
    tick();
    bvalid_vec = 8'h00;
    tick();
    bvalid_vec = 8'h05;
    #1;
    n_vec++; if (accept_en !== 8'h00 || busy !== 1'b1) begin n_err++;
      $display("FAIL rmid_blocked: got %h/%b want 00/1", accept_en, busy); end
    cpurst_b = 1'b0;
    #1;
    n_vec++; if (piu_bvalid !== 4'b0000 || bid !== 8'h00 || busy !== 1'b0) begin n_err++;
      $display("FAIL rmid_clear: got %b/%h/%b want 0000/00/0", piu_bvalid, bid, busy); end
    n_vec++; if (accept_en !== 8'h00) begin n_err++;
      $display("FAIL rmid_accept_in_reset: got %h want 00", accept_en); end
    tick();
    cpurst_b = 1'b1;
    #1;
    n_vec++; if (accept_en !== 8'h01) begin n_err++;
      $display("FAIL rmid_after_release: got %h want 01", accept_en); end
    tick();
    bvalid_vec = 8'h00;
    #1;
    n_vec++; if (piu_bvalid !== 4'b0001 || bid !== 8'h5A) begin n_err++;
      $display("FAIL rmid_slot: got %b/%h want 0001/5a", piu_bvalid, bid); end
  endtask

`ifdef EBIU_NCWT_BRESP_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [1:0] br [6] = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
    int e;
    do_reset();
    bready = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      e = c % 2;
      set_entry(e, 8'(c), br[c], 4'b0001);
      bvalid_vec = 8'h01 << e;
      #1;
      tick();
    end
    bvalid_vec = '0;
    tick();
    n_vec++; if (err_cnt !== 8'd4) begin n_err++;
      $display("FAIL errcnt_mix: got %0d want 4", err_cnt); end
    for (int c = 0; c < 300; c++) begin
      e = c % 2;
      set_entry(e, 8'(c), 2'b10, 4'b0001);
      bvalid_vec = 8'h01 << e;
      #1;
      tick();
    end
    bvalid_vec = '0;
    tick();
    n_vec++; if (err_cnt !== 8'hFF) begin n_err++;
      $display("FAIL errcnt_sat: got %h want ff", err_cnt); end
  endtask
`endif

  initial begin
    cpurst_b   = 1'b1;
    bvalid_vec = '0;
    bus_flat   = '0;
    sel_flat   = '0;
    bready     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_broadcast();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
`ifdef EBIU_NCWT_BRESP_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ct_ebiu_ncwt_bresp_arb.md
Name: ct_ebiu_ncwt_bresp_arb

Overview:
- Downstream consumer of the NC write-table entries: arbitrates among entries presenting a write response (bvalid) and returns {id, bresp} to the owning PIU(s) over a valid/ready B channel.
- Generates the per-entry accept pulse that the entry uses to set its resp_done and retire.
- Sits between the ncwt entry array and the per-PIU B-response return ports in the EBIU.

Parameters:
- NCWT_NUM, 8, number of ncwt entries arbitrated (power of 2, 2..16).
- PIU_NUM, 4, number of PIU return ports.

Ports:
- ncwt_ctrl_clk  in  1  clock.
- cpurst_b  in  1  reset.
- ncwt_bvalid_vec  in  NCWT_NUM  per-entry ncwt_bvalid_x.
- ncwt_bus_flat  in  NCWT_NUM*10  per-entry {id[7:0], bresp[1:0]}; entry i occupies [10i+9:10i].
- ncwt_piu_sel_flat  in  NCWT_NUM*PIU_NUM  per-entry PIU select; entry i occupies [4i+3:4i].
- piu_ebiu_bready  in  PIU_NUM  per-PIU ready.
- ncwt_bresp_accept_en  out  NCWT_NUM  one-hot accept pulse; bit i drives entry i's ncwt_bresp_accept_en_x.
- ebiu_piu_bvalid  out  PIU_NUM  per-PIU response valid.
- ebiu_piu_bid  out  8  response id, shared by all PIUs.
- ebiu_piu_bresp  out  2  response code, shared by all PIUs.
- ncwt_bresp_busy  out  1  output slot occupied.

Behaviour:
Reset interface:
- Reset cpurst_b, asynchronous, active-low; clock ncwt_ctrl_clk.
- Reset values: ebiu_piu_bvalid=0, bid=0, bresp=0, round-robin pointer=0, busy=0.
- ncwt_bresp_accept_en is combinational and is 0 while the slot is blocked.

Output slot:
- One register holding {id, bresp, pend[PIU_NUM-1:0]}; busy = |pend.
- ebiu_piu_bvalid = pend.
- Each PIU handshake (bvalid[p] & bready[p]) clears pend[p] at the next edge.
- A broadcast response (several sel bits set) stays in the slot until every selected PIU has handshaken. PIUs complete independently, in any order.

Arbitration:
- slot_free = !busy, or the slot empties this cycle (every remaining pend bit sees bready).
- When slot_free and |ncwt_bvalid_vec, pick the first requester at or after rr_ptr, scanning with wrap-around.
- Assert ncwt_bresp_accept_en[g] in the same cycle. Load the slot at the edge with pend = that entry's sel vector.
- rr_ptr <= g+1 modulo NCWT_NUM.
- Back-to-back throughput is one response per cycle when all targeted PIUs are ready.

Latency and timing:
- Entry bvalid to ebiu_piu_bvalid: 1 cycle when the slot is free.
- The entry's bvalid drops the cycle after accept, because resp_done is registered. The arbiter applies no extra mask; an entry asserting bvalid again in that cycle is a protocol violation and is caught by an assertion.

Boundary conditions:
- A granted entry with all-zero sel is accepted and dropped, and the slot stays empty. An assertion flags this case.
- Simultaneous last-PIU handshake and new grant: the slot is reloaded with no bubble.
- No requesters: no accept, pointer holds.
- Reset mid-transfer: the slot clears immediately and the response is lost. The ncwt entries reset on the same cpurst_b, so state stays consistent.
- Inputs are sampled only while slot_free; data is stable from grant through the edge.

Optional Feature:
- Macro EBIU_NCWT_BRESP_ERR_CNT_EN.
- Defined: adds output ncwt_bresp_err_cnt[7:0], a saturating count of accepted responses with bresp[1]=1 (SLVERR/DECERR). It increments at the load edge, holds at 8'hFF, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package ct_ebiu_ncwt_pkg holds:
  - NCWT_BUS_W=10 and field offsets ID_LSB=2, BRESP_LSB=0.
  - BRESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - The NCWT_NUM default.
- One sub-module: ct_ebiu_rr_arb_nc, a parameterised round-robin picker (req, ptr -> one-hot grant plus encoded index). It is reusable by the ncrd return path.

Test Plan:
- Single requester: entry 3 bvalid, sel=4'b0010, id=0x23, bresp=00, piu1 bready=1 -> accept_en=8'h08 in cycle 0; ebiu_piu_bvalid=4'b0010, bid=0x23 in cycle 1; busy=0 in cycle 2.
- Round-robin fairness: entries 0,2,5 held valid (each drops after accept and reasserts after 2 cycles), all PIUs ready -> grant order 0,2,5,0,2,5; no entry starved.
- Broadcast with staggered ready: sel=4'b1111, piu0/2 ready at cycle 1, piu1 at cycle 3, piu3 at cycle 5 -> bvalid goes 1111->1010->1000->0000; next grant occurs in cycle 5 with no bubble.
- Back-pressure: piu2 bready=0 for 10 cycles with entry 1 (sel 0100) in the slot and entry 6 waiting -> no accept for entry 6 until piu2 ready; then accept_en=8'h40 in the same cycle as the piu2 handshake.
- Error count (macro on): 3 responses with bresp=10, 1 with 11, 2 with 00 -> ncwt_bresp_err_cnt=4. Forcing 300 error responses -> counter saturates at 8'hFF.
- Reset mid-operation: assert cpurst_b low while bvalid=4'b0101 -> all outputs 0 immediately; after release, rr_ptr=0 and the first grant goes to the lowest requester.
